// File: rtl/shr_pkg.sv
// Shared definitions for the sequential barrel shifter: FSM encoding, datapath width
// and the per-stage shift amounts applied on successive cycles.
package shr_pkg;

    localparam int DATA_W      = 32;
    localparam int AMT_W       = 5;
    localparam int STAGE_COUNT = 5;

    localparam logic [2:0] STG_LAST = 3'(STAGE_COUNT - 1);

    // Stage 0 handles the MSB of the shift amount, stage 4 the LSB.
    localparam logic [AMT_W-1:0] STAGE_AMT [STAGE_COUNT] = '{5'd16, 5'd8, 5'd4, 5'd2, 5'd1};

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/shr_stage.sv
// Combinational conditional right shift by one stage amount; vacated MSBs take the fill bit.
module shr_stage
    import shr_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [AMT_W-1:0]  amt,
    input  logic              en,
    input  logic              fill,
    output logic [DATA_W-1:0] result
);

    logic [DATA_W-1:0] fill_mask;
    logic [DATA_W-1:0] shifted;

    always_comb begin
        fill_mask = ~({DATA_W{1'b1}} >> amt);
        shifted   = (data >> amt) | (fill ? fill_mask : '0);
        result    = en ? shifted : data;
    end

endmodule

// File: rtl/shr_seq.sv
// Sequential 32-bit right shifter: one log-shifter stage per cycle, fixed 5-cycle latency,
// logical or arithmetic fill, registered result held until the next completion.
module shr_seq
    import shr_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              arith,
    input  logic [AMT_W-1:0]  sh_amt,
    input  logic [DATA_W-1:0] d_in,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] d_out
);

    state_t            state_reg, state_next;
    logic [2:0]        stg_reg, stg_next;
    logic [DATA_W-1:0] work_reg, work_next;
    logic [AMT_W-1:0]  amt_reg, amt_next;
    logic              arith_reg, arith_next;
    logic              done_reg, done_next;
    logic [DATA_W-1:0] d_out_reg, d_out_next;

    logic [DATA_W-1:0] stage_out;
    logic              stage_en;
    logic              stage_fill;

    // Arithmetic shifts never alter bit 31, so the working register's MSB still
    // carries the captured operand's sign at every stage.
    assign stage_en   = amt_reg[STG_LAST - stg_reg];
    assign stage_fill = arith_reg & work_reg[DATA_W-1];

    shr_stage u_stage (
        .data   (work_reg),
        .amt    (STAGE_AMT[stg_reg]),
        .en     (stage_en),
        .fill   (stage_fill),
        .result (stage_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            stg_reg   <= '0;
            work_reg  <= '0;
            amt_reg   <= '0;
            arith_reg <= 1'b0;
            done_reg  <= 1'b0;
            d_out_reg <= '0;
        end else begin
            state_reg <= state_next;
            stg_reg   <= stg_next;
            work_reg  <= work_next;
            amt_reg   <= amt_next;
            arith_reg <= arith_next;
            done_reg  <= done_next;
            d_out_reg <= d_out_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        stg_next   = stg_reg;
        work_next  = work_reg;
        amt_next   = amt_reg;
        arith_next = arith_reg;
        done_next  = 1'b0;
        d_out_next = d_out_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    work_next  = d_in;
                    amt_next   = sh_amt;
                    arith_next = arith;
                    stg_next   = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                work_next = stage_out;
                if (stg_reg == STG_LAST) begin
                    d_out_next = stage_out;
                    done_next  = 1'b1;
                    stg_next   = '0;
                    state_next = IDLE;
                end else begin
                    stg_next = stg_reg + 3'd1;
                end
            end
            default: begin
                state_next = IDLE;
                stg_next   = '0;
            end
        endcase
    end

    assign busy  = (state_reg == SHIFT);
    assign done  = done_reg;
    assign d_out = d_out_reg;

endmodule

// File: doc/shr_seq.md
SHR_SEQ -- requirements
Module: shr_seq

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 bits and shift amount at 5 bits.
REQ-002 CLK  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 RST_N  input  1  reset, asynchronous assert, active-low; this polarity and synchronicity are fixed.
REQ-004 START  input  1  request pulse; sampled only in IDLE.
REQ-005 ARITH  input  1  1 = arithmetic right shift (sign fill), 0 = logical (zero fill); sampled with START.
REQ-006 SH_AMT  input  5  shift amount 0..31; sampled with START.
REQ-007 D_IN  input  32  operand; sampled with START.
REQ-008 BUSY  output  1  high while a shift is in progress.
REQ-009 DONE  output  1  one-cycle pulse; D_OUT valid from this cycle on.
REQ-010 D_OUT  output  32  result; held until the next completion.

Function
REQ-011 The FSM SHALL have states IDLE and SHIFT, plus a 3-bit stage index STG (0..4).
REQ-012 In IDLE with START=1, the block SHALL capture D_IN into the working register, SH_AMT and ARITH into holding registers, set STG=0, and enter SHIFT.
REQ-013 In SHIFT, each edge SHALL apply one stage: STG 0,1,2,3,4 shifts right by 16,8,4,2,1 respectively when SH_AMT bit 4,3,2,1,0 is 1, else passes unchanged.
REQ-014 Vacated MSBs SHALL be filled with bit 31 of the captured operand when ARITH=1, with 0 when ARITH=0.
REQ-015 On the edge that applies stage STG=4, the block SHALL load D_OUT with the final value, assert DONE for exactly one cycle, and return to IDLE.
REQ-016 Latency SHALL be fixed at 5 cycles: START sampled at edge t implies DONE=1 in the cycle after edge t+5, independent of SH_AMT (including 0).
REQ-017 BUSY SHALL be 1 exactly while in SHIFT and 0 in the DONE cycle.
REQ-018 START while BUSY=1 SHALL be ignored; inputs SHALL not affect the operation in flight.
REQ-019 START in the DONE cycle SHALL be accepted (state is IDLE); back-to-back operations SHALL complete every 6 cycles.
REQ-020 D_OUT SHALL change only on a DONE edge; changes on D_IN/SH_AMT/ARITH outside the START sample SHALL have no effect.
REQ-021 Result SHALL equal D_IN >> SH_AMT (logical) or D_IN >>> SH_AMT (arithmetic) as 32-bit values.

Reset
REQ-022 RST_N=0 SHALL immediately force IDLE, STG=0, BUSY=0, DONE=0, D_OUT=32'h0, and clear working/holding registers.
REQ-023 Reset asserted mid-operation SHALL abort it; no DONE SHALL be produced for the aborted request.
REQ-024 After RST_N deasserts, the first rising edge SHALL be able to accept START.

Structure
REQ-025 A shared package shr_pkg SHALL hold the state encoding (IDLE, SHIFT), the stage count (5), and the stage-amount table (16,8,4,2,1).
REQ-026 One sub-module shr_stage SHALL implement a combinational conditional right shift by a selected stage amount with a fill bit; shr_seq SHALL instantiate it once and reuse it across cycles.
REQ-027 Datapath SHALL be a single 32-bit working register plus D_OUT; no combinational path from inputs to D_OUT.

Verification
REQ-028 D_IN=32'h8000_00F0, SH_AMT=4, ARITH=0, START at edge t -> DONE in cycle after t+5, D_OUT=32'h0800_000F, BUSY high for 5 cycles.
REQ-029 D_IN=32'h8000_00F0, SH_AMT=4, ARITH=1 -> D_OUT=32'hF800_000F; SH_AMT=31, ARITH=1 -> 32'hFFFF_FFFF; SH_AMT=31, ARITH=0 -> 32'h0000_0001.
REQ-030 SH_AMT=0, D_IN=32'h1234_5678 -> D_OUT=32'h1234_5678 after the full 5-cycle latency.
REQ-031 START pulsed again at cycles t+2 with different D_IN -> ignored, first result unchanged; START in DONE cycle -> second result DONE exactly 6 cycles after first.
REQ-032 RST_N low at t+3 of an operation -> BUSY=0, D_OUT=0 immediately, no DONE pulse; fresh START after release completes normally.
REQ-033 Random sweep of 1000 (D_IN, SH_AMT, ARITH) -> every D_OUT matches the REQ-021 model.
